// File: rtl/frame_scaler_pkg.sv
// frame_scaler_pkg
//   Shared definitions for the frame scaler: mode encodings, FSM states and
//   small helpers that turn a mode into a scale shift and output dimensions.
//   Imported by the interface, the delay line and the top.
package frame_scaler_pkg;

  // Mode encodings as presented on the 3-bit mode input; 5..7 are invalid.
  localparam logic [2:0] MODE_COPY = 3'd0;
  localparam logic [2:0] MODE_UP2  = 3'd1;
  localparam logic [2:0] MODE_UP4  = 3'd2;
  localparam logic [2:0] MODE_DN2  = 3'd3;
  localparam logic [2:0] MODE_DN4  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic mode_valid(input logic [2:0] m);
    return m <= MODE_DN4;
  endfunction

  function automatic logic mode_is_down(input logic [2:0] m);
    return (m == MODE_DN2) || (m == MODE_DN4);
  endfunction

  // log2 of the scale factor; copy (and anything invalid) is factor 1.
  function automatic logic [1:0] mode_shift(input logic [2:0] m);
    case (m)
      MODE_UP2, MODE_DN2: return 2'd1;
      MODE_UP4, MODE_DN4: return 2'd2;
      default:            return 2'd0;
    endcase
  endfunction

  // Output extent along one axis for a source extent of dim pixels.
  function automatic int unsigned scaled_dim(input int unsigned dim, input logic [2:0] m);
    case (m)
      MODE_COPY: return dim;
      MODE_UP2:  return dim * 2;
      MODE_UP4:  return dim * 4;
      MODE_DN2:  return dim / 2;
      MODE_DN4:  return dim / 4;
      default:   return dim;
    endcase
  endfunction

endpackage

// File: rtl/frame_scaler_if.sv
// frame_scaler_if
//   Bundles the control handshake and the ROM-read / RAM-write buses of the
//   frame scaler.
//   master : the scaler (drives rom_addr, ram_*, busy, done, err)
//   slave  : the environment (drives start, mode, pixel_rom)
//   Signals:
//     start, mode         frame request and scale mode
//     rom_addr, pixel_rom source image read address / returned pixel
//     ram_addr, ram_data, ram_we  framebuffer write port
//     busy, done, err     status levels
interface frame_scaler_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 19
);
  logic              start;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  pixel_rom;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, mode, pixel_rom,
    output rom_addr, ram_addr, ram_data, ram_we, busy, done, err
  );

  modport slave (
    output start, mode, pixel_rom,
    input  rom_addr, ram_addr, ram_data, ram_we, busy, done, err
  );
endinterface

// File: rtl/frame_scaler_delay_line.sv
// scaler_delay_line
//   DEPTH-stage register chain used to delay the write strobe and write
//   address so they line up with pixel data returning from the ROM.
//   All stages clear on reset so a reset drops the strobe immediately.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     d         value entering the chain
//     q         value leaving the chain DEPTH cycles later
module scaler_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [W-1:0] q_reg;
    logic [W-1:0] d_in;

    if (gi == 0) begin : g_head
      assign d_in = d;
    end else begin : g_tail
      assign d_in = g_stage[gi-1].q_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_reg <= '0;
      end else begin
        q_reg <= d_in;
      end
    end
  end

  assign q = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/frame_scaler.sv
// frame_scaler
//   Streams a stored source image out of a ROM into a framebuffer RAM,
//   rescaling on the fly: 1:1 copy, nearest-neighbour upscale x2/x4, or
//   decimating downscale /2 and /4. One source address is issued per cycle in
//   output raster order; the write strobe/address are delayed by the ROM
//   latency so each RAM write carries the pixel of its own address.
//   Optional build macro SCALER_CENTER_EN: when defined the image is centred in
//   the framebuffer (offset computed at start from the requested mode); when
//   undefined the image is anchored at framebuffer address 0.
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   frame_scaler_if.master: start/mode in, rom_addr out, pixel_rom in,
//           ram_addr/ram_data/ram_we out, busy/done/err status out
module frame_scaler
  import frame_scaler_pkg::*;
#(
  parameter int unsigned IN_W    = 160,
  parameter int unsigned IN_H    = 120,
  parameter int unsigned FB_W    = 640,
  parameter int unsigned FB_H    = 480,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned ROM_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  frame_scaler_if.master bus
);

  // The largest output (x4) must fit the framebuffer, the framebuffer must
  // fit the address space, and the ROM latency is bounded by the drain counter.
  if ((IN_W * 4 > FB_W) || (IN_H * 4 > FB_H)) begin : g_size_err
    $error("frame_scaler: x4 upscaled image exceeds framebuffer");
  end
  if (FB_W * FB_H > (1 << ADDR_W)) begin : g_addr_err
    $error("frame_scaler: framebuffer does not fit ADDR_W");
  end
  if ((ROM_LAT < 1) || (ROM_LAT > 4)) begin : g_lat_err
    $error("frame_scaler: ROM_LAT must be 1..4");
  end

  state_e            state_reg, state_next;
  logic [2:0]        mode_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] x_out_reg, y_out_reg;
  logic [ADDR_W-1:0] src_base_reg;   // y_src * IN_W
  logic [ADDR_W-1:0] dst_base_reg;   // y_out * FB_W
  logic [2:0]        drain_reg;

  logic [1:0]        shift;
  logic              down;
  logic [ADDR_W-1:0] out_w, out_h;
  logic [ADDR_W-1:0] x_src;
  logic [ADDR_W-1:0] y_next;
  logic [ADDR_W-1:0] src_row_step;
  logic              src_row_adv;
  logic              last_x, last_y;
  logic              accept_start, mode_ok;
  logic [ADDR_W-1:0] offset;
  logic              run;
  logic [ADDR_W:0]   dl_d, dl_q;
  logic [PIX_W-1:0]  pix;

  assign accept_start = bus.start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign mode_ok      = mode_valid(bus.mode);
  assign run          = (state_reg == ST_RUN);

  always_comb begin
    shift        = mode_shift(mode_reg);
    down         = mode_is_down(mode_reg);
    out_w        = ADDR_W'(scaled_dim(IN_W, mode_reg));
    out_h        = ADDR_W'(scaled_dim(IN_H, mode_reg));
    x_src        = down ? (x_out_reg << shift) : (x_out_reg >> shift);
    y_next       = y_out_reg + 1'b1;
    // Upscaling repeats each source row 2^shift times, so the source row base
    // only moves when the next output row index is a multiple of the factor.
    // Downscaling skips 2^shift source rows on every output row.
    src_row_adv  = down || ((y_next & ((ADDR_W'(1) << shift) - 1'b1)) == '0);
    src_row_step = down ? (ADDR_W'(IN_W) << shift) : ADDR_W'(IN_W);
    last_x       = (x_out_reg == out_w - 1'b1);
    last_y       = (y_out_reg == out_h - 1'b1);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept_start) begin
          state_next = mode_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (last_x && last_y) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == 3'(ROM_LAT - 1)) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters and row-base accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg     <= MODE_COPY;
      err_reg      <= 1'b0;
      x_out_reg    <= '0;
      y_out_reg    <= '0;
      src_base_reg <= '0;
      dst_base_reg <= '0;
      drain_reg    <= '0;
    end else if (accept_start) begin
      mode_reg     <= bus.mode;
      err_reg      <= !mode_ok;
      x_out_reg    <= '0;
      y_out_reg    <= '0;
      src_base_reg <= '0;
      dst_base_reg <= '0;
      drain_reg    <= '0;
    end else if (state_reg == ST_RUN) begin
      if (last_x) begin
        x_out_reg    <= '0;
        y_out_reg    <= y_next;
        dst_base_reg <= dst_base_reg + ADDR_W'(FB_W);
        if (src_row_adv) begin
          src_base_reg <= src_base_reg + src_row_step;
        end
      end else begin
        x_out_reg <= x_out_reg + 1'b1;
      end
    end else if (state_reg == ST_DRAIN) begin
      drain_reg <= drain_reg + 1'b1;
    end
  end

`ifdef SCALER_CENTER_EN
  // Centring offset for the mode being started; constant-factor arithmetic
  // evaluated once per frame.
  function automatic logic [ADDR_W-1:0] centre_offset(input logic [2:0] m);
    int unsigned w;
    int unsigned h;
    w = scaled_dim(IN_W, m);
    h = scaled_dim(IN_H, m);
    return ADDR_W'(((FB_H - h) / 2) * FB_W + (FB_W - w) / 2);
  endfunction

  logic [ADDR_W-1:0] offset_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_reg <= '0;
    end else if (accept_start) begin
      offset_reg <= centre_offset(bus.mode);
    end
  end

  assign offset = offset_reg;
`else
  assign offset = '0;
`endif

  // Write strobe and address leave the counters in the same cycle as the ROM
  // address and are delayed to meet the returning pixel.
  assign dl_d = run ? {1'b1, offset + dst_base_reg + x_out_reg} : '0;

  scaler_delay_line #(
    .DEPTH (ROM_LAT),
    .W     (ADDR_W + 1)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (dl_d),
    .q   (dl_q)
  );

  assign pix          = bus.pixel_rom;
  assign bus.rom_addr = run ? (src_base_reg + x_src) : '0;
  assign bus.ram_we   = dl_q[ADDR_W];
  assign bus.ram_addr = dl_q[ADDR_W-1:0];
  assign bus.ram_data = dl_q[ADDR_W] ? pix : '0;
  assign bus.busy     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.err      = (state_reg == ST_DONE) && err_reg;

endmodule
